// File: rtl/mul_controller_if.sv
// Handshake and strobe bundle between the multiplier controller, its host
// and the repeated-addition datapath.
//   master : host/datapath side (drives start, abort, eqz)
//   slave  : controller side (drives strobes, status and iteration count)
interface mul_controller_if;
  logic        start;
  logic        abort;
  logic        eqz;
  logic        lda;
  logic        ldb;
  logic        clrp;
  logic        ldp;
  logic        decb;
  logic        ready;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] iter_cnt;

  modport master (
    output start, abort, eqz,
    input  lda, ldb, clrp, ldp, decb, ready, busy, done, err, iter_cnt
  );

  modport slave (
    input  start, abort, eqz,
    output lda, ldb, clrp, ldp, decb, ready, busy, done, err, iter_cnt
  );
endinterface

// File: rtl/mul_controller.sv
// Sequencer for the repeated-addition multiplier datapath.
// Loads A, loads B while clearing P, then issues one P+=A / B-=1 step per
// cycle until the datapath reports B==0. Supports synchronous abort and a
// saturating count of add cycles.
// Optional watchdog: define MULCTRL_TIMEOUT_EN to stop after MAX_ITER add
// cycles and pulse err instead of done.
module mul_controller #(
  parameter logic [15:0] MAX_ITER = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  mul_controller_if.slave  bus
);

`ifdef MULCTRL_TIMEOUT_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    ADD    = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    ADD    = 3'd3,
    DONE   = 3'd4
  } state_t;
`endif

  state_t      state_reg;
  state_t      state_next;
  logic [15:0] iter_cnt_reg;

  // Registered state decodes; the strobes are gated afterwards by abort/eqz.
  logic        lda_en_reg;
  logic        ldb_en_reg;
  logic        add_en_reg;
  logic        ready_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        timeout_hit;
  logic        add_step;

`ifdef MULCTRL_TIMEOUT_EN
  logic        err_reg;
  assign timeout_hit = add_en_reg && (iter_cnt_reg == MAX_ITER);
`else
  // Watchdog limit has no effect in this build.
  logic        unused_max_iter;
  assign unused_max_iter = ^MAX_ITER;
  assign timeout_hit     = 1'b0;
`endif

  // An add step happens in ADD while B is non-zero and the watchdog has not
  // tripped; abort suppresses the strobes separately.
  assign add_step = add_en_reg && !bus.eqz && !timeout_hit;

  // Next-state selection; abort overrides every other input.
  always_comb begin
    state_next = state_reg;
    if (bus.abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    state_next = bus.start ? LOAD_A : IDLE;
        LOAD_A:  state_next = LOAD_B;
        LOAD_B:  state_next = ADD;
        ADD: begin
          if (bus.eqz)
            state_next = DONE;
`ifdef MULCTRL_TIMEOUT_EN
          else if (timeout_hit)
            state_next = ERR;
`endif
          else
            state_next = ADD;
        end
        DONE:    state_next = IDLE;
`ifdef MULCTRL_TIMEOUT_EN
        ERR:     state_next = IDLE;
`endif
        default: state_next = IDLE;
      endcase
    end
  end

  // State register, registered decodes and the saturating add counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      iter_cnt_reg <= 16'd0;
      lda_en_reg   <= 1'b0;
      ldb_en_reg   <= 1'b0;
      add_en_reg   <= 1'b0;
      ready_reg    <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
`ifdef MULCTRL_TIMEOUT_EN
      err_reg      <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      lda_en_reg <= (state_next == LOAD_A);
      ldb_en_reg <= (state_next == LOAD_B);
      add_en_reg <= (state_next == ADD);
      ready_reg  <= (state_next == IDLE);
      busy_reg   <= (state_next == LOAD_A) || (state_next == LOAD_B) ||
                    (state_next == ADD);
      done_reg   <= (state_next == DONE);
`ifdef MULCTRL_TIMEOUT_EN
      err_reg    <= (state_next == ERR);
`endif
      if (!bus.abort) begin
        if (ldb_en_reg)
          iter_cnt_reg <= 16'd0;
        else if (add_step && (iter_cnt_reg != 16'hFFFF))
          iter_cnt_reg <= iter_cnt_reg + 16'd1;
      end
    end
  end

  assign bus.lda      = lda_en_reg && !bus.abort;
  assign bus.ldb      = ldb_en_reg && !bus.abort;
  assign bus.clrp     = ldb_en_reg && !bus.abort;
  assign bus.ldp      = add_step && !bus.abort;
  assign bus.decb     = add_step && !bus.abort;
  assign bus.ready    = ready_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg && !bus.abort;
`ifdef MULCTRL_TIMEOUT_EN
  assign bus.err      = err_reg && !bus.abort;
`else
  assign bus.err      = 1'b0;
`endif
  assign bus.iter_cnt = iter_cnt_reg;

endmodule

// File: tb/tb_mul_controller.sv
// Directed bench for mul_controller with a behavioural repeated-addition
// datapath (A, B, P registers) driven by the controller strobes.
module tb_mul_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_in;
  logic [15:0] a_dp = 16'd0;
  logic [15:0] b_dp = 16'd0;
  logic [15:0] p_dp = 16'd0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_controller_if bus ();

`ifdef MULCTRL_TIMEOUT_EN
  localparam logic [15:0] TB_MAX_ITER = 16'd4;
`else
  localparam logic [15:0] TB_MAX_ITER = 16'hFFFF;
`endif

  mul_controller #(.MAX_ITER(TB_MAX_ITER)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Datapath model
  assign bus.eqz = (b_dp == 16'd0);

  always @(posedge clk) begin
    if (bus.lda) a_dp <= data_in;
    if (bus.ldb) b_dp <= data_in;
    else if (bus.decb) b_dp <= b_dp - 16'd1;
    if (bus.clrp) p_dp <= 16'd0;
    else if (bus.ldp) p_dp <= p_dp + a_dp;
  end

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One multiply. c counts cycles after the edge that samples start
  // (c=1 LOAD_A, c=2 LOAD_B, c>=3 ADD...). kill_at is the 1-based ADD
  // cycle in which abort (or reset) is applied; 0 means none.
  task automatic run_mul(input string name, input logic [15:0] a,
                         input logic [15:0] b, input int kill_at,
                         input bit kill_by_reset, input bit junk_start,
                         output int n_add, output int n_done,
                         output int n_err, output int done_cyc);
    int c;
    bit fin;
    n_add = 0; n_done = 0; n_err = 0; done_cyc = -1;
    @(negedge clk);
    bus.start = 1'b1;
    data_in   = 16'd0;
    @(negedge clk);
    bus.start = 1'b0;
    data_in   = a;
    #1;
    check_val({name, ".lda"},  bus.lda,  1);
    check_val({name, ".busy"}, bus.busy, 1);
    @(negedge clk);
    data_in = b;
    #1;
    check_val({name, ".ldb"},      bus.ldb,  1);
    check_val({name, ".clrp"},     bus.clrp, 1);
    check_val({name, ".lda_off"},  bus.lda,  0);
    c   = 2;
    fin = 1'b0;
    while (!fin && c < 60) begin
      @(negedge clk);
      c++;
      data_in   = 16'd0;
      bus.start = junk_start && (c == 3);
      if (kill_at != 0 && c == kill_at + 2) begin
        if (kill_by_reset) rst_n = 1'b0;
        else bus.abort = 1'b1;
        #1;
        check_val({name, ".kill_strobes"},
                  {bus.lda, bus.ldb, bus.clrp, bus.ldp, bus.decb, bus.done, bus.err}, 0);
        if (kill_by_reset) begin
          check_val({name, ".rst_ready"}, bus.ready, 1);
          check_val({name, ".rst_busy"},  bus.busy,  0);
          check_val({name, ".rst_iter"},  bus.iter_cnt, 0);
        end
        @(negedge clk);
        bus.abort = 1'b0;
        rst_n     = 1'b1;
        #1;
        check_val({name, ".idle_after_kill"}, bus.ready, 1);
        fin = 1'b1;
      end else begin
        #1;
        if (bus.ldp) n_add++;
        if (bus.ldp != bus.decb) check_val({name, ".ldp_decb"}, bus.decb, bus.ldp);
        if (bus.done) begin n_done++; done_cyc = c; end
        if (bus.err) n_err++;
        if (bus.ready) fin = 1'b1;
      end
    end
    bus.start = 1'b0;
    check_val({name, ".bound"}, fin, 1);
    $display("op %s a=%0d b=%0d adds=%0d done=%0d err=%0d done_cyc=%0d iter=%0d p=%0d",
             name, a, b, n_add, n_done, n_err, done_cyc, bus.iter_cnt, p_dp);
  endtask

  initial begin
    int n_add, n_done, n_err, done_cyc;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    data_in   = 16'd0;
    repeat (2) @(negedge clk);
    #1;
    check_val("reset.ready", bus.ready, 1);
    check_val("reset.busy",  bus.busy,  0);
    check_val("reset.strobes",
              {bus.lda, bus.ldb, bus.clrp, bus.ldp, bus.decb, bus.done, bus.err}, 0);
    check_val("reset.iter",  bus.iter_cnt, 0);
    $display("reset released");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted in the 4th ADD cycle: 3 adds happened before it.
    run_mul("rst_mid", 16'd3, 16'd9, 4, 1'b1, 1'b0, n_add, n_done, n_err, done_cyc);
    check_val("rst_mid.adds", n_add,  3);
    check_val("rst_mid.done", n_done, 0);

    // 7 x 5
    run_mul("mul7x5", 16'd7, 16'd5, 0, 1'b0, 1'b0, n_add, n_done, n_err, done_cyc);
    check_val("mul7x5.adds",     n_add,    5);
    check_val("mul7x5.done",     n_done,   1);
    check_val("mul7x5.done_cyc", done_cyc, 9);
    check_val("mul7x5.err",      n_err,    0);
    check_val("mul7x5.iter",     bus.iter_cnt, 5);
    check_val("mul7x5.p",        p_dp,     35);

    // 9 x 0: no adds, product cleared
    run_mul("mul9x0", 16'd9, 16'd0, 0, 1'b0, 1'b0, n_add, n_done, n_err, done_cyc);
    check_val("mul9x0.adds",     n_add,    0);
    check_val("mul9x0.done",     n_done,   1);
    check_val("mul9x0.done_cyc", done_cyc, 4);
    check_val("mul9x0.iter",     bus.iter_cnt, 0);
    check_val("mul9x0.p",        p_dp,     0);

    // 2 x 6 aborted in the 3rd ADD cycle, stray start while busy
    run_mul("abort2x6", 16'd2, 16'd6, 3, 1'b0, 1'b1, n_add, n_done, n_err, done_cyc);
    check_val("abort2x6.adds", n_add,  2);
    check_val("abort2x6.done", n_done, 0);
    check_val("abort2x6.iter", bus.iter_cnt, 2);
    check_val("abort2x6.p",    p_dp,   4);
    @(negedge clk);
    #1;
    check_val("abort2x6.still_idle", bus.ready, 1);

    // 3 x 10: watchdog (limit 4) or full run
    run_mul("mul3x10", 16'd3, 16'd10, 0, 1'b0, 1'b0, n_add, n_done, n_err, done_cyc);
`ifdef MULCTRL_TIMEOUT_EN
    check_val("mul3x10.adds", n_add,  4);
    check_val("mul3x10.err",  n_err,  1);
    check_val("mul3x10.done", n_done, 0);
    check_val("mul3x10.iter", bus.iter_cnt, 4);
    check_val("mul3x10.p",    p_dp,   12);
`else
    check_val("mul3x10.adds",     n_add,    10);
    check_val("mul3x10.err",      n_err,    0);
    check_val("mul3x10.done",     n_done,   1);
    check_val("mul3x10.done_cyc", done_cyc, 14);
    check_val("mul3x10.iter",     bus.iter_cnt, 10);
    check_val("mul3x10.p",        p_dp,     30);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_controller.md
# mul_controller

Control FSM that sequences the repeated-addition multiplier datapath: it loads operand A, loads operand B while clearing the product register, then drives one add-and-decrement step per cycle until the B counter reports zero. It sits between a host that issues `start` and presents operands on the shared 16-bit `data_in` bus, and the datapath it drives through `lda`/`ldb`/`ldp`/`clrp`/`decb`, observing `eqz`. It adds a host handshake, an abort path, an iteration counter and an optional watchdog.

## Interface
- `MAX_ITER`, default 16'hFFFF: watchdog limit on add cycles (used only with `MULCTRL_TIMEOUT_EN`).
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  begin a multiply; sampled only in IDLE.
- `abort`  input  1  synchronous abort; returns to IDLE from any state.
- `eqz`  input  1  datapath B-counter-equals-zero flag (combinational from B).
- `lda`  output  1  load A register from `data_in`.
- `ldb`  output  1  load B counter from `data_in`.
- `clrp`  output  1  clear product register.
- `ldp`  output  1  load product register with P+A.
- `decb`  output  1  decrement B counter.
- `ready`  output  1  high in IDLE.
- `busy`  output  1  high in LOAD_A, LOAD_B, ADD.
- `done`  output  1  one-cycle pulse: product valid.
- `err`  output  1  one-cycle pulse: watchdog expiry (constant 0 without the macro).
- `iter_cnt`  output  16  add cycles performed in the current/last operation.

## Operation
- States: IDLE, LOAD_A, LOAD_B, ADD, DONE, ERR (ERR exists only with the macro).
- IDLE: `ready`=1. `start`=1 -> LOAD_A; else stay.
- LOAD_A: `lda`=1; host holds operand A on `data_in` this cycle. -> LOAD_B.
- LOAD_B: `ldb`=1, `clrp`=1; host holds operand B on `data_in`. `iter_cnt` cleared to 0. -> ADD.
- ADD (Mealy on `eqz`): if `eqz`=0, `ldp`=1, `decb`=1, `iter_cnt`+=1, stay; if `eqz`=1, no strobes, -> DONE.
- DONE: `done`=1 for one cycle, -> IDLE. `iter_cnt` holds its final value until the next LOAD_B.
- Exactly one datapath strobe group is active per cycle; `ldp` and `decb` are always asserted together.
- `abort`=1 in any state: the next state is IDLE, all strobes are 0 in that cycle, no `done`/`err`. `abort` takes priority over `start` and `eqz`.
- `start` outside IDLE is ignored (not queued).
- B=0: the first ADD cycle sees `eqz`=1; zero adds, product = 0 (cleared).
- `iter_cnt` saturates at 16'hFFFF and never wraps.

## Timing
- Reset (`rst_n`=0, asynchronous): state=IDLE, `iter_cnt`=0, `lda`/`ldb`/`clrp`/`ldp`/`decb`/`done`/`err`/`busy`=0, `ready`=1.
- `ready` and `busy` are state decodes. `ldp`/`decb` depend combinationally on `eqz` in ADD. All other outputs are state decodes.
- Latency: `start` sampled at edge k -> LOAD_A after k, LOAD_B after k+1, ADD from k+2, `done` high in the cycle after edge k+B+3 (B = operand value).
- Back-to-back: `start` high during the DONE cycle is ignored. The earliest accepted `start` is in the following IDLE cycle.
- Reset asserted mid-operation: immediate return to IDLE, strobes deasserted asynchronously. Datapath contents are undefined and not cleared by this block.

## Configuration
- `MULCTRL_TIMEOUT_EN` defined: in ADD with `eqz`=0 and `iter_cnt`==`MAX_ITER`, no strobes are issued and the next state is ERR. ERR pulses `err` for one cycle, then -> IDLE. `done` is not asserted.
- `MULCTRL_TIMEOUT_EN` undefined: no ERR state, `err` tied 0, `MAX_ITER` ignored, ADD loops until `eqz`.

## Test plan
- Reset mid-ADD (A=3, B=9, `rst_n` low at the 4th ADD cycle) -> immediately `ready`=1, all strobes 0, `iter_cnt`=0.
- A=7, B=5, `start` at edge k -> `lda` after k, `ldb`+`clrp` after k+1, 5 cycles of `ldp`+`decb`, `done` after k+8, `iter_cnt`=5, datapath P=35.
- A=9, B=0 -> zero `ldp` cycles, `done` after k+3, `iter_cnt`=0, P=0.
- A=2, B=6, `abort` pulsed in the 3rd ADD cycle -> strobes 0 in that cycle, IDLE next, no `done`. `start` while `busy` is ignored.
- With `MULCTRL_TIMEOUT_EN`, `MAX_ITER`=4, B=10 -> 4 add cycles, `err` pulse, no `done`, `iter_cnt`=4. Without the macro, the same stimulus gives 10 adds and `done`.
